// File: rtl/synaptic_update_sequencer.sv
`timescale 1ns/1ps
// synaptic_update_sequencer
// Sweeps every synapse word after a training sample. Rows are visited in
// pre-neuron order. Each row starts with a one-cycle pre-spike fetch. Each
// word in the row then gets a read cycle followed by a write-back cycle, so
// the FF-STDP lanes can rewrite the word in place.
//
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   START, IS_TRAIN            sweep request; IS_TRAIN=0 skips straight to DONE
//   HOLD                       stalls PRE_RD/SYN_RD (never splits a read/write pair)
//   BUSY, DONE                 sweep in progress / one-cycle completion pulse
//   CTRL_SYNARRAY_CS/WE/ADDR   synaptic SRAM port, ADDR = {pre, word}
//   CTRL_GRAD_ARRAY_CS/WE      gradient SRAM strobes
//   CTRL_PRE_NEURON_ADDRESS    current row
//   CTRL_POST_NEURON_ADDRESS   word * POST_NEUR_PARALLEL
//   CTRL_TREF_EVENT            update strobe, high on every write-back
//
// Build option: define SYN_GRAD_ACCUM_EN to make the gradient strobes follow
// the synaptic strobes. Without it the gradient bank is never selected.
//
// All outputs come straight from flops. They are decoded from the state
// register, so the visible outputs trail the state by one cycle.
module synaptic_update_sequencer #(
    parameter int INPUT_NEURON         = 784,
    parameter int OUTPUT_NEURON        = 256,
    parameter int POST_NEUR_PARALLEL   = 4,
    parameter int PRE_NEUR_ADDR_WIDTH  = 10,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            START,
    input  logic                            IS_TRAIN,
    input  logic                            HOLD,
    output logic                            BUSY,
    output logic                            DONE,
    output logic                            CTRL_SYNARRAY_CS,
    output logic                            CTRL_SYNARRAY_WE,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
    output logic                            CTRL_GRAD_ARRAY_CS,
    output logic                            CTRL_GRAD_ARRAY_WE,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEURON_ADDRESS,
    output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
    output logic                            CTRL_TREF_EVENT
);

    localparam int WPR     = OUTPUT_NEURON / POST_NEUR_PARALLEL;
    localparam int WPR_LOG = (WPR > 1) ? $clog2(WPR) : 0;
    localparam int WORD_W  = (WPR > 1) ? WPR_LOG : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_RD,
        S_SYN_RD,
        S_SYN_WR,
        S_FIN
    } state_t;

    state_t                          state_q, state_d;
    logic [PRE_NEUR_ADDR_WIDTH-1:0]  pre_q, pre_d;
    logic [WORD_W-1:0]               word_q, word_d;

    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            cs_q, cs_d;
    logic                            we_q, we_d;
    logic                            tref_q, tref_d;
    logic [SYN_ARRAY_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PRE_NEUR_ADDR_WIDTH-1:0]  pre_addr_q, pre_addr_d;
    logic [POST_NEUR_ADDR_WIDTH-1:0] post_addr_q, post_addr_d;

    logic last_word, last_pre, active;

    assign last_word = (word_q == WORD_W'(WPR - 1));
    assign last_pre  = (pre_q == PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1));
    assign active    = (state_q == S_PRE_RD) || (state_q == S_SYN_RD) ||
                       (state_q == S_SYN_WR);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                // DONE is still visible during the first IDLE cycle. Treat that
                // cycle as part of completion, so a START there is dropped.
                if (START && !done_q) begin
                    if (IS_TRAIN) begin
                        state_d = S_PRE_RD;
                        pre_d   = '0;
                        word_d  = '0;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_PRE_RD: if (!HOLD) state_d = S_SYN_RD;
            S_SYN_RD: if (!HOLD) state_d = S_SYN_WR;
            S_SYN_WR: begin
                if (!last_word) begin
                    word_d  = word_q + WORD_W'(1);
                    state_d = S_SYN_RD;
                end else if (!last_pre) begin
                    pre_d   = pre_q + PRE_NEUR_ADDR_WIDTH'(1);
                    word_d  = '0;
                    state_d = S_PRE_RD;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode, registered on the next edge
    always_comb begin
        busy_d      = active;
        done_d      = (state_q == S_FIN);
        // A held read keeps its address but drops the chip select.
        cs_d        = ((state_q == S_SYN_RD) && !HOLD) || (state_q == S_SYN_WR);
        we_d        = (state_q == S_SYN_WR);
        tref_d      = (state_q == S_SYN_WR);
        addr_d      = '0;
        pre_addr_d  = '0;
        post_addr_d = '0;
        if (active) begin
            addr_d      = (SYN_ARRAY_ADDR_WIDTH'(pre_q) << WPR_LOG) |
                          SYN_ARRAY_ADDR_WIDTH'(word_q);
            pre_addr_d  = pre_q;
            post_addr_d = POST_NEUR_ADDR_WIDTH'(int'(word_q) * POST_NEUR_PARALLEL);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            pre_q       <= '0;
            word_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            tref_q      <= 1'b0;
            addr_q      <= '0;
            pre_addr_q  <= '0;
            post_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            word_q      <= word_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            tref_q      <= tref_d;
            addr_q      <= addr_d;
            pre_addr_q  <= pre_addr_d;
            post_addr_q <= post_addr_d;
        end
    end

    assign BUSY                     = busy_q;
    assign DONE                     = done_q;
    assign CTRL_SYNARRAY_CS         = cs_q;
    assign CTRL_SYNARRAY_WE         = we_q;
    assign CTRL_SYNARRAY_ADDR       = addr_q;
    assign CTRL_PRE_NEURON_ADDRESS  = pre_addr_q;
    assign CTRL_POST_NEURON_ADDRESS = post_addr_q;
    assign CTRL_TREF_EVENT          = tref_q;

`ifdef SYN_GRAD_ACCUM_EN
    assign CTRL_GRAD_ARRAY_CS = cs_q;
    assign CTRL_GRAD_ARRAY_WE = we_q;
`else
    assign CTRL_GRAD_ARRAY_CS = 1'b0;
    assign CTRL_GRAD_ARRAY_WE = 1'b0;
`endif

endmodule
